// File: rtl/ppu_pkg.sv
// Shared PPU definitions: op tag encoding and the result record that
// travels from the pipeline into the result FIFO.
package ppu_pkg;

  localparam int N       = 16;
  localparam int OP_SIZE = 2;

  typedef enum logic [OP_SIZE-1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } ppu_op_e;

  // One retired result together with the op that produced it.
  typedef struct packed {
    ppu_op_e        op;
    logic [N-1:0]   result;
  } ppu_result_t;

endpackage

// File: rtl/ppu_result_fifo_if.sv
// Pipeline-side and consumer-side handshake of the PPU result FIFO.
// The slave modport is the FIFO itself; master is the surrounding logic.
interface ppu_result_fifo_if
  import ppu_pkg::*;
#(
  parameter int N = 16
);

  logic               pipe_valid_i;
  logic [N-1:0]       pipe_result_i;
  logic [OP_SIZE-1:0] pipe_op_i;

  logic               out_valid_o;
  logic               out_ready_i;
  logic [N-1:0]       out_result_o;
  logic [OP_SIZE-1:0] out_op_o;

  modport slave (
    input  pipe_valid_i, pipe_result_i, pipe_op_i, out_ready_i,
    output out_valid_o, out_result_o, out_op_o
  );

  modport master (
    output pipe_valid_i, pipe_result_i, pipe_op_i, out_ready_i,
    input  out_valid_o, out_result_o, out_op_o
  );

endinterface

// File: rtl/ppu_fifo_mem.sv
// Storage array for the result FIFO: one synchronous write port and one
// asynchronous read port so the head entry falls straight through.
module ppu_fifo_mem #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write the addressed entry when the top accepts a push.
  // NOTE: contents carry no reset; validity comes from the pointers, so
  // clearing the array would only add reset fan-out for nothing.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/ppu_result_fifo.sv
// First-word-fall-through result buffer behind the PPU pipeline. Holds
// pointers, the almost-full back-pressure flag and the sticky overflow.
module ppu_result_fifo
  import ppu_pkg::*;
#(
  parameter int N     = 16,
  parameter int DEPTH = 8,
  parameter int SLACK = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  ppu_result_fifo_if.slave         bus,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     almost_full_o,
  output logic                     overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int W  = N + OP_SIZE;
  localparam logic [PW-1:0] AF_LEVEL = PW'(DEPTH - SLACK);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          overflow_q, overflow_d;

  logic          empty, full, pop, push, drop;
  logic [W-1:0]  head;

  // Full when indexes match but the wrap bits differ; empty when equal.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                 (wr_ptr_q[AW] != rd_ptr_q[AW]);

  // A pop frees a slot in the same cycle, so push-while-full is legal
  // as long as the consumer takes the head.
  assign pop  = !empty && bus.out_ready_i;
  assign push = bus.pipe_valid_i && (!full || pop);
  assign drop = bus.pipe_valid_i && full && !pop;

  // Next-state for pointers and the sticky overflow flag.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (drop) overflow_d = 1'b1;
  end

  // State register with synchronous reset; stored entries are discarded
  // simply by collapsing the pointers.
  // NOTE: non-blocking assignments keep every register sampling the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  ppu_fifo_mem #(
    .WIDTH (W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk       (clk),
    .wr_en_i   (push),
    .wr_addr_i (wr_ptr_q[AW-1:0]),
    .wr_data_i ({bus.pipe_op_i, bus.pipe_result_i}),
    .rd_addr_i (rd_ptr_q[AW-1:0]),
    .rd_data_o (head)
  );

  assign bus.out_valid_o  = !empty;
  assign bus.out_result_o = head[N-1:0];
  assign bus.out_op_o     = head[W-1:N];

  // Occupancy and back-pressure come from registered pointers only.
  assign count_o       = wr_ptr_q - rd_ptr_q;
  assign almost_full_o = (count_o >= AF_LEVEL);
  assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_ppu_result_fifo.sv
// Self-checking bench for ppu_result_fifo (N=16, DEPTH=8, SLACK=3):
// a vector table for reset/stream/fill/overflow/drain, then a randomised
// wrap-around run against a queue model and a mid-burst reset.
module tb_ppu_result_fifo;
  import ppu_pkg::*;

  localparam int DEPTH = 8;
  localparam int SLACK = 3;

  logic       clk;
  logic       rst;
  logic [3:0] count;
  logic       almost_full;
  logic       overflow;

  ppu_result_fifo_if #(.N(16)) bus ();

  ppu_result_fifo #(.N(16), .DEPTH(DEPTH), .SLACK(SLACK)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus.slave),
    .count_o       (count),
    .almost_full_o (almost_full),
    .overflow_o    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        valid;
    logic [15:0] result;
    logic [1:0]  op;
    logic        ready;
    logic        exp_valid;
    logic [15:0] exp_result;
    logic [1:0]  exp_op;
    logic [3:0]  exp_count;
    logic        exp_af;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic r, input logic v, input logic [15:0] d, input logic [1:0] o,
                     input logic rdy, input logic ev, input logic [15:0] ed, input logic [1:0] eo,
                     input logic [3:0] ec, input logic eaf, input logic eovf);
    vec_t t;
    t.rst = r; t.valid = v; t.result = d; t.op = o; t.ready = rdy;
    t.exp_valid = ev; t.exp_result = ed; t.exp_op = eo;
    t.exp_count = ec; t.exp_af = eaf; t.exp_ovf = eovf;
    vecs.push_back(t);
  endtask

  task automatic check_state(input string tag, input logic ev, input logic [15:0] ed,
                             input logic [1:0] eo, input logic [3:0] ec,
                             input logic eaf, input logic eovf);
    check({tag, ".valid"}, 32'(bus.out_valid_o), 32'(ev));
    check({tag, ".count"}, 32'(count), 32'(ec));
    check({tag, ".af"},    32'(almost_full), 32'(eaf));
    check({tag, ".ovf"},   32'(overflow), 32'(eovf));
    if (ev) begin
      check({tag, ".result"}, 32'(bus.out_result_o), 32'(ed));
      check({tag, ".op"},     32'(bus.out_op_o), 32'(eo));
    end
  endtask

  function automatic logic [15:0] fill_val(input int k);
    return 16'h0100 + 16'(k);
  endfunction

  ppu_result_t sb[$];
  ppu_result_t ent;
  logic        m_push, m_pop, v, rdy;
  int          pushed, cyc;

  initial begin
    rst = 1'b0;
    bus.pipe_valid_i  = 1'b0;
    bus.pipe_result_i = '0;
    bus.pipe_op_i     = '0;
    bus.out_ready_i   = 1'b0;

    // Reset with random inputs on the bus.
    add(1, 1, 16'($urandom), 2'($urandom), 1, 0, 0, 0, 0, 0, 0);
    // Streaming: each result is the head one cycle after its push.
    add(0, 1, 16'h4000, 2'd0, 1, 1, 16'h4000, 2'd0, 1, 0, 0);
    add(0, 1, 16'h3000, 2'd1, 1, 1, 16'h3000, 2'd1, 1, 0, 0);
    add(0, 1, 16'h5000, 2'd2, 1, 1, 16'h5000, 2'd2, 1, 0, 0);
    add(0, 0, 16'h0000, 2'd0, 1, 0, 0, 0, 0, 0, 0);
    // Fill with the consumer stalled; almost_full rises at 5, full at 8.
    for (int k = 0; k < 8; k++)
      add(0, 1, fill_val(k), 2'(k), 0, 1, fill_val(0), 2'd0, 4'(k + 1), (k + 1) >= 5, 0);
    // Push and pop together while full: count holds, nothing dropped.
    add(0, 1, 16'h7FFF, 2'd3, 1, 1, fill_val(1), 2'd1, 8, 1, 0);
    // Push into a full FIFO with no pop: dropped, overflow latches.
    add(0, 1, 16'h1234, 2'd2, 0, 1, fill_val(1), 2'd1, 8, 1, 1);
    // Drain: A2..A7 then 0x7FFF last; overflow stays set.
    for (int k = 2; k < 8; k++)
      add(0, 0, 0, 0, 1, 1, fill_val(k), 2'(k), 4'(9 - k), (9 - k) >= 5, 1);
    add(0, 0, 0, 0, 1, 1, 16'h7FFF, 2'd3, 1, 0, 1);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    // Only reset clears the sticky overflow.
    add(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst               = vecs[i].rst;
      bus.pipe_valid_i  = vecs[i].valid;
      bus.pipe_result_i = vecs[i].result;
      bus.pipe_op_i     = vecs[i].op;
      bus.out_ready_i   = vecs[i].ready;
      tick();
      check_state($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_result,
                  vecs[i].exp_op, vecs[i].exp_count, vecs[i].exp_af, vecs[i].exp_ovf);
    end
    rst = 1'b0;

    // Wrap-around: 20 results through a queue model, random ready duty,
    // issue gated by almost_full as the real pipeline would be.
    pushed = 0;
    cyc    = 0;
    while ((pushed < 20 || sb.size() > 0) && cyc < 400) begin
      v   = (pushed < 20) && (sb.size() < DEPTH - SLACK) && ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      ent.result = 16'(pushed * 37 + 16'h2005);
      ent.op     = ppu_op_e'(pushed[1:0]);
      bus.pipe_valid_i  = v;
      bus.pipe_result_i = ent.result;
      bus.pipe_op_i     = ent.op;
      bus.out_ready_i   = rdy;
      m_pop  = (sb.size() > 0) && rdy;
      m_push = v && ((sb.size() < DEPTH) || m_pop);
      if (m_pop)  void'(sb.pop_front());
      if (m_push) begin
        sb.push_back(ent);
        pushed++;
      end
      tick();
      cyc++;
      if (sb.size() > 0)
        check_state("wrap", 1, sb[0].result, sb[0].op, 4'(sb.size()), sb.size() >= 5, 0);
      else
        check_state("wrap", 0, 0, 0, 0, 0, 0);
    end
    if (cyc >= 400) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wrap_budget: got %0d pushes, queue %0d, required 20 pushes and empty", pushed, sb.size());
    end

    // Mid-burst reset: three stored entries and a push during reset all vanish.
    bus.out_ready_i  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.pipe_valid_i  = 1'b1;
      bus.pipe_result_i = 16'h6000 + 16'(k);
      bus.pipe_op_i     = 2'(k);
      tick();
    end
    check_state("preburst", 1, 16'h6000, 2'd0, 3, 0, 0);
    rst = 1'b1;
    bus.pipe_result_i = 16'h6ABC;
    tick();
    check_state("midrst", 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    bus.pipe_valid_i = 1'b0;
    tick();
    check_state("postrst", 0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
